// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deframes
// 11-bit frames with odd parity and folds set-2 prefixes (E0/F0/E1) into key events.
module ps2_kbd_decoder #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       pause_strobe
);

  localparam logic [3:0]  FILT_L = 4'(FILTER - 1);
  localparam logic [15:0] TO_L   = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic       clk_p0, clk_p1, dat_p0, dat_p1;
  logic       filt_clk;
  logic [3:0] fcnt;
  logic       fall_p2, bit_p2;

  state_t      state;
  logic [2:0]  bcnt;
  logic [7:0]  shift;
  logic        par;
  logic [15:0] tcnt;
  logic        ext, brk;
  logic [2:0]  skip;

  // Odd parity over data+parity bit, and a stop bit of 1.
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
    return ((^d) ^ p) & s;
  endfunction

  // Stages p0/p1: two-flop synchronisers; p2: glitch filter and falling-edge detect.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_p0   <= 1'b1;
      clk_p1   <= 1'b1;
      dat_p0   <= 1'b1;
      dat_p1   <= 1'b1;
      filt_clk <= 1'b1;
      fcnt     <= '0;
      fall_p2  <= 1'b0;
      bit_p2   <= 1'b1;
    end else begin
      clk_p0  <= ps2_kbd_clk;
      clk_p1  <= clk_p0;
      dat_p0  <= ps2_kbd_data;
      dat_p1  <= dat_p0;
      fall_p2 <= 1'b0;
      if (clk_p1 != filt_clk) begin
        if (fcnt == FILT_L) begin
          filt_clk <= clk_p1;
          fcnt     <= '0;
          if (!clk_p1) begin
            fall_p2 <= 1'b1;
            bit_p2  <= dat_p1;
          end
        end else begin
          fcnt <= fcnt + 4'd1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Frame FSM, timeout and event decoder act on the filtered edge pulse.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= IDLE;
      bcnt         <= '0;
      shift        <= '0;
      par          <= 1'b0;
      tcnt         <= '0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      skip         <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_err       <= 1'b0;
      key_strobe   <= 1'b0;
      key_code     <= '0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      pause_strobe <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_err       <= 1'b0;
      key_strobe   <= 1'b0;
      pause_strobe <= 1'b0;

      if (state == IDLE || fall_p2) tcnt <= '0;
      else                          tcnt <= tcnt + 16'd1;

      if (fall_p2) begin
        case (state)
          IDLE: begin
            if (!bit_p2) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
          DATA: begin
            shift <= {bit_p2, shift[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= bit_p2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (frame_ok(shift, par, bit_p2)) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
              if (skip != 3'd0) begin
                // Bytes of a Pause sequence are swallowed, never reported as keys.
                skip <= skip - 3'd1;
                if (skip == 3'd1) begin
                  pause_strobe <= 1'b1;
                  ext          <= 1'b0;
                  brk          <= 1'b0;
                end
              end else begin
                case (shift)
                  8'hE0: ext  <= 1'b1;
                  8'hF0: brk  <= 1'b1;
                  8'hE1: skip <= 3'd7;
                  default: begin
                    key_code     <= shift;
                    key_pressed  <= ~brk;
                    key_extended <= ext;
                    key_strobe   <= 1'b1;
                    ext          <= 1'b0;
                    brk          <= 1'b0;
                  end
                endcase
              end
            end else begin
              rx_err <= 1'b1;
              ext    <= 1'b0;
              brk    <= 1'b0;
              skip   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TO_L) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: drives PS/2 frames and checks bytes, key events and strobes.
module tb_ps2_kbd_decoder;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 4096;
  localparam int HALF    = 25;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err, key_strobe;
  logic [7:0] key_code;
  logic       key_pressed, key_extended, pause_strobe;

  ps2_kbd_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .key_strobe(key_strobe), .key_code(key_code), .key_pressed(key_pressed),
    .key_extended(key_extended), .pause_strobe(pause_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor sampled on the falling edge of clk_sys.
  int c_rx = 0, c_key = 0, c_err = 0, c_pause = 0, c_key_rx = 0, c_long = 0;
  logic [7:0] l_rx = 8'h00, l_code = 8'h00;
  logic l_pr = 1'b0, l_ext = 1'b0;
  logic p_rx = 1'b0, p_key = 1'b0, p_err = 1'b0, p_pause = 1'b0;

  always @(negedge clk_sys) begin
    if (rx_valid) begin c_rx++; l_rx = rx_byte; end
    if (key_strobe) begin
      c_key++; l_code = key_code; l_pr = key_pressed; l_ext = key_extended;
      if (rx_valid) c_key_rx++;
    end
    if (rx_err) c_err++;
    if (pause_strobe) c_pause++;
    if ((rx_valid && p_rx) || (key_strobe && p_key) || (rx_err && p_err) || (pause_strobe && p_pause))
      c_long++;
    p_rx = rx_valid; p_key = key_strobe; p_err = rx_err; p_pause = pause_strobe;
  end

  int s_rx, s_key, s_err, s_pause, s_krx;

  task automatic snap();
    s_rx = c_rx; s_key = c_key; s_err = c_err; s_pause = c_pause; s_krx = c_key_rx;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk_sys);
    ps2_kbd_data = b;
    repeat (HALF) @(negedge clk_sys);
    ps2_kbd_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (HALF) @(negedge clk_sys);
  endtask

  initial begin
    repeat (4) @(negedge clk_sys);
    chk("reset_rx_byte", 32'(rx_byte), 32'h0);
    chk("reset_strobes", {28'h0, rx_valid, rx_err, key_strobe, pause_strobe}, 32'h0);
    chk("reset_key", {23'h0, key_code, key_pressed}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);

    // Plain make code 1C
    snap();
    send(8'h1C, 1'b0);
    chk("make_rx_cnt", 32'(c_rx - s_rx), 32'd1);
    chk("make_rx_byte", 32'(l_rx), 32'h1C);
    chk("make_key_cnt", 32'(c_key - s_key), 32'd1);
    chk("make_same_cycle", 32'(c_key_rx - s_krx), 32'd1);
    chk("make_fields", {23'h0, l_code, l_pr, l_ext}, {23'h0, 8'h1C, 1'b1, 1'b0});

    // Break F0 1C
    snap();
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    chk("brk_key_cnt", 32'(c_key - s_key), 32'd1);
    chk("brk_fields", {23'h0, l_code, l_pr, l_ext}, {23'h0, 8'h1C, 1'b0, 1'b0});

    // Extended break E0 F0 75
    snap();
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    chk("ebrk_rx_cnt", 32'(c_rx - s_rx), 32'd3);
    chk("ebrk_key_cnt", 32'(c_key - s_key), 32'd1);
    chk("ebrk_fields", {23'h0, l_code, l_pr, l_ext}, {23'h0, 8'h75, 1'b0, 1'b1});

    // Parity error clears the pending E0
    snap();
    send(8'hE0, 1'b0);
    send(8'h29, 1'b1);
    chk("perr_err_cnt", 32'(c_err - s_err), 32'd1);
    chk("perr_rx_cnt", 32'(c_rx - s_rx), 32'd1);
    chk("perr_key_cnt", 32'(c_key - s_key), 32'd0);
    send(8'h29, 1'b0);
    chk("perr_next_key", 32'(c_key - s_key), 32'd1);
    chk("perr_next_fields", {23'h0, l_code, l_pr, l_ext}, {23'h0, 8'h29, 1'b1, 1'b0});

    // Aborted frame recovered by timeout
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    send(8'h29, 1'b0);
    chk("tmo_key_cnt", 32'(c_key - s_key), 32'd1);
    chk("tmo_err_cnt", 32'(c_err - s_err), 32'd0);
    chk("tmo_code", 32'(l_code), 32'h29);

    // Pause sequence
    snap();
    send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
    send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0);
    chk("pause_early", 32'(c_pause - s_pause), 32'd0);
    send(8'h77, 1'b0);
    chk("pause_rx_cnt", 32'(c_rx - s_rx), 32'd8);
    chk("pause_cnt", 32'(c_pause - s_pause), 32'd1);
    chk("pause_key_cnt", 32'(c_key - s_key), 32'd0);

    // Reset mid-frame, then a short clock glitch, then a clean frame
    send(8'h5A, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("rst_rx_byte", 32'(rx_byte), 32'h0);
    chk("rst_key", {22'h0, key_code, key_pressed, key_extended}, 32'h0);
    chk("rst_strobes", {28'h0, rx_valid, rx_err, key_strobe, pause_strobe}, 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    snap();
    ps2_kbd_data = 1'b0;
    ps2_kbd_clk  = 1'b0;
    repeat (FILTER - 2) @(negedge clk_sys);
    ps2_kbd_clk  = 1'b1;
    repeat (3) @(negedge clk_sys);
    ps2_kbd_data = 1'b1;
    repeat (20) @(negedge clk_sys);
    send(8'h5A, 1'b0);
    chk("post_rst_rx_cnt", 32'(c_rx - s_rx), 32'd1);
    chk("post_rst_err", 32'(c_err - s_err), 32'd0);
    chk("post_rst_key_cnt", 32'(c_key - s_key), 32'd1);
    chk("post_rst_fields", {23'h0, l_code, l_pr, l_ext}, {23'h0, 8'h5A, 1'b1, 1'b0});

    chk("strobe_width", 32'(c_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
